// File: rtl/rr_encoder8to3_if.sv
// Request/grant bundle for the round-robin 8-to-3 encoder.
// The master drives requests and ready; the slave returns the grant index, valid and pending.
interface rr_encoder8to3_if;
   logic [7:0] d;
   logic       ready;
   logic [2:0] s;
   logic       valid;
   logic [7:0] pending;

   modport master (output d, ready, input s, valid, pending);
   modport slave  (input d, ready, output s, valid, pending);
endinterface

// File: rtl/rr_encoder8to3.sv
// Round-robin 8-to-3 encoder: sticky request register, round-robin winner select,
// and a one-entry valid/ready output register that can reload back-to-back.
module rr_encoder8to3 (
   input  logic               clk,
   input  logic               rst_n,
   rr_encoder8to3_if.slave    bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t     state;
   logic [7:0] pending_q;
   logic [2:0] ptr_q;
   logic [2:0] s_q;
   logic [2:0] win;
   logic       load;
   logic [7:0] clr;

   // Walk downward so the lowest offset from ptr is the last assignment and wins.
   always_comb begin
      win = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         if (pending_q[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
      end
   end

   assign load = ((state == EMPTY) || bus.ready) && (|pending_q);
   assign clr  = load ? (8'h01 << win) : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         pending_q <= 8'h00;
         ptr_q     <= 3'd0;
         s_q       <= 3'd0;
      end else begin
         // Set wins over clear: a re-request of the winner survives its load.
         pending_q <= (pending_q & ~clr) | bus.d;
         case (state)
            EMPTY: begin
               if (load) begin
                  s_q   <= win;
                  ptr_q <= win + 3'd1;
                  state <= FULL;
               end
            end
            FULL: begin
               if (bus.ready) begin
                  if (load) begin
                     s_q   <= win;
                     ptr_q <= win + 3'd1;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign bus.s       = s_q;
   assign bus.valid   = (state == FULL);
   assign bus.pending = pending_q;
endmodule

// File: tb/tb_rr_encoder8to3.sv
// Directed and randomized checks of rr_encoder8to3 against a cycle-level reference model.
module tb_rr_encoder8to3;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rr_encoder8to3_if bus();

   rr_encoder8to3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   bit [7:0] m_pend;
   int       m_ptr;
   int       m_s;
   bit       m_val;

   function automatic void model_reset();
      m_pend = 8'h00;
      m_ptr  = 0;
      m_s    = 0;
      m_val  = 1'b0;
   endfunction

   function automatic void model_step(input bit [7:0] dv, input bit rv);
      int win;
      win = -1;
      for (int k = 0; k < 8; k++)
         if (win < 0 && m_pend[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
      if ((!m_val || rv) && win >= 0) begin
         m_pend[win] = 1'b0;
         m_s         = win;
         m_val       = 1'b1;
         m_ptr       = (win + 1) % 8;
      end else if (rv) begin
         m_val = 1'b0;
      end
      m_pend = m_pend | dv;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"},   {7'd0, bus.valid}, {7'd0, m_val});
      chk({tag, ".pending"}, bus.pending, m_pend);
      if (m_val) chk({tag, ".s"}, {5'd0, bus.s}, 8'(m_s));
   endtask

   // One clock: drive on the falling edge, step the model at the rising edge, sample 1 later.
   task automatic cyc(input logic [7:0] dv, input logic rv, input string tag);
      @(negedge clk);
      bus.d     = dv;
      bus.ready = rv;
      @(posedge clk);
      model_step(dv, rv);
      #1;
      chk_model(tag);
   endtask

   // Asynchronous reset asserted between edges and checked before the next edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.d = 8'h00;
      bus.ready = 1'b0;
      model_reset();
      #1;
      chk({tag, ".s"},       {5'd0, bus.s}, 8'h00);
      chk({tag, ".valid"},   {7'd0, bus.valid}, 8'h00);
      chk({tag, ".pending"}, bus.pending, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b1;
      bus.d     = 8'h00;
      bus.ready = 1'b0;
      model_reset();

      do_reset("reset_cold");

      // Single request
      cyc(8'h04, 1'b1, "single_req");
      chk("single_pending", bus.pending, 8'h04);
      chk("single_notvalid", {7'd0, bus.valid}, 8'h00);
      cyc(8'h00, 1'b1, "single_grant");
      chk("single_s", {5'd0, bus.s}, 8'h02);
      chk("single_valid", {7'd0, bus.valid}, 8'h01);
      cyc(8'h00, 1'b1, "single_drain");
      chk("single_empty", {7'd0, bus.valid}, 8'h00);
      // ptr is now 3: with bits 0 and 3 pending, 3 must be granted first
      cyc(8'h09, 1'b1, "ptr3_req");
      cyc(8'h00, 1'b1, "ptr3_g0");
      chk("ptr3_first", {5'd0, bus.s}, 8'h03);
      cyc(8'h00, 1'b1, "ptr3_g1");
      chk("ptr3_second", {5'd0, bus.s}, 8'h00);
      cyc(8'h00, 1'b1, "ptr3_drain");

      // Burst from reset
      do_reset("reset_burst");
      cyc(8'hFF, 1'b1, "burst_req");
      for (int i = 0; i < 8; i++) begin
         cyc(8'h00, 1'b1, "burst");
         chk("burst_s", {5'd0, bus.s}, 8'(i));
         chk("burst_valid", {7'd0, bus.valid}, 8'h01);
      end
      cyc(8'h00, 1'b1, "burst_end");
      chk("burst_empty", {7'd0, bus.valid}, 8'h00);

      // Wrap: grant 5 leaves ptr at 6, then 0 beats 5
      cyc(8'h20, 1'b1, "wrap_pre");
      cyc(8'h00, 1'b1, "wrap_g5");
      chk("wrap_first5", {5'd0, bus.s}, 8'h05);
      cyc(8'h21, 1'b1, "wrap_req");
      cyc(8'h00, 1'b1, "wrap_g0");
      chk("wrap_s0", {5'd0, bus.s}, 8'h00);
      cyc(8'h00, 1'b1, "wrap_g5b");
      chk("wrap_s5", {5'd0, bus.s}, 8'h05);
      cyc(8'h00, 1'b1, "wrap_drain");

      // Reset while holding s=3
      do_reset("reset_pre_hold");
      cyc(8'h08, 1'b0, "hold_req");
      cyc(8'h00, 1'b0, "hold_g3");
      chk("hold_s3", {5'd0, bus.s}, 8'h03);
      cyc(8'h40, 1'b0, "hold_more");
      do_reset("reset_mid_hold");

      // Backpressure
      cyc(8'h08, 1'b0, "bp_req");
      cyc(8'h00, 1'b0, "bp_g3");
      for (int i = 0; i < 5; i++) begin
         cyc(8'h80, 1'b0, "bp_hold");
         chk("bp_s_stable", {5'd0, bus.s}, 8'h03);
         chk("bp_pending", bus.pending, 8'h80);
      end
      cyc(8'h00, 1'b1, "bp_release");
      chk("bp_s7", {5'd0, bus.s}, 8'h07);
      chk("bp_valid", {7'd0, bus.valid}, 8'h01);
      cyc(8'h00, 1'b1, "bp_drain");

      // Set/clear collision on index 4
      do_reset("reset_coll");
      cyc(8'h50, 1'b1, "coll_req");
      cyc(8'h10, 1'b1, "coll_load4");
      chk("coll_s4", {5'd0, bus.s}, 8'h04);
      chk("coll_pend", bus.pending, 8'h50);
      cyc(8'h00, 1'b1, "coll_g6");
      chk("coll_s6", {5'd0, bus.s}, 8'h06);
      cyc(8'h00, 1'b1, "coll_g4");
      chk("coll_s4b", {5'd0, bus.s}, 8'h04);
      cyc(8'h00, 1'b1, "coll_drain");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [7:0] rd;
         rd = 8'($urandom) & 8'($urandom) & 8'($urandom);
         cyc(rd, 1'($urandom_range(0, 3) != 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_encoder8to3.md
# rr_encoder8to3

Sequential 8-to-3 round-robin encoder: the encode-side counterpart of the 3-to-8 decoder. It collects request pulses on eight one-hot lines into a sticky pending register, selects one pending line per grant in round-robin order, and presents its 3-bit binary index through a valid/ready output handshake. It sits upstream of `decoder3to8`, so a registered `s` index can be regenerated into a one-hot select downstream.

## Interface
- No parameters. Widths are fixed at 8 request lines and a 3-bit index.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  asynchronous, active-low reset. It clears all state immediately.
- `d`  input  8  request lines. `d[i]` high at a rising edge requests index `i`. Level or pulse; merged into `pending`.
- `ready`  input  1  downstream accepts `s` at an edge where `valid`=1. Ignored while `valid`=0.
- `s`  output  3  encoded index of the held grant. Registered.
- `valid`  output  1  `s` holds a grant not yet accepted. Registered.
- `pending`  output  8  latched requests not yet loaded into `s`. Registered.

## Operation
- Internal state: `pending[7:0]`, round-robin pointer `ptr[2:0]`, output register `s`, and `valid`, which acts as a 2-state FSM (EMPTY: `valid`=0; FULL: `valid`=1).
- Load condition: `load` = (`valid`=0 OR `ready`=1) AND |`pending`.
- Selection:
  - Search `pending` starting at `ptr`, then `ptr`+1, and so on, wrapping mod 8 (7 wraps to 0).
  - The first set bit `i` is the winner.
  - Selection is combinational from the registered `pending`; the same-cycle `d` is not considered.
- On `load` at an edge:
  - `s` <= `i`
  - `valid` <= 1
  - `ptr` <= (`i`+1) mod 8
  - `pending[i]` is cleared.
- Pending update each edge: `pending` <= (`pending` & ~clr) | `d`, where clr is one-hot(`i`) on `load` and 0 otherwise. Set wins over clear, so a re-request of `i` in its load cycle is retained.
- FSM transitions:
  - EMPTY to FULL on `load`.
  - FULL with `ready`=1 and `pending`=0: to EMPTY.
  - FULL with `ready`=1 and `pending`!=0: stays FULL and loads the next winner at the same edge (back-to-back, no bubble).
  - FULL with `ready`=0: hold. `s`, `valid` and `ptr` are stable; `pending` still accumulates `d`.
- Duplicate requests for a bit already pending merge into that one bit; no request counting.
- The index in `s` is not present in `pending` unless it was re-requested.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): `s`=0, `valid`=0, `pending`=8'h00, `ptr`=0.
- Reset mid-operation: a held grant and all pending requests are dropped. The first edge after `rst_n` rises behaves as from cold reset.
- Latency:
  - `d[i]` high at edge k, with the block EMPTY and nothing else pending: `pending[i]`=1 after edge k, and `valid`=1, `s`=`i` after edge k+1.
  - Minimum request-to-valid latency: 2 edges.
- Throughput: one grant per clock while `ready`=1 and `pending` is non-empty.
- Handshake: a transfer occurs at an edge where `valid`=1 and `ready`=1. While `valid`=1 and `ready`=0, `s` must not change.
- Priority wrap: with `ptr`=6 and `pending`=8'b0010_0001, the grant order is 0, then 5.

## Test plan
- Reset: drive `rst_n` low asynchronously (also mid-hold with `valid`=1, `s`=3) -> `s`=0, `valid`=0, `pending`=0 immediately, before the next edge.
- Single request: `d`=8'h04 for one edge, `ready`=1 -> `pending`=8'h04 one cycle later, then `s`=2, `valid`=1 for exactly one cycle, then `valid`=0, `pending`=0, `ptr`=3.
- Burst: `d`=8'hFF for one edge from reset, `ready`=1 held -> `s` = 0,1,2,3,4,5,6,7 on 8 consecutive cycles with `valid`=1 throughout, then `valid`=0, `ptr`=0.
- Round-robin wrap: grant 5 first (`ptr`=6), then `d`=8'b0010_0001 -> next grants are `s`=0, then `s`=5.
- Backpressure: `valid`=1, `s`=3, `ready`=0 for 5 cycles while `d`=8'h80 pulses -> `s` stays 3 and `pending`=8'h80. When `ready` rises, the next cycle gives `s`=7, `valid`=1 with no bubble.
- Set/clear collision: `d[4]` high at the edge where index 4 loads, with `pending[6]` also set -> `pending[4]` stays 1. Grants follow as `s`=4, then 6, then 4.
